// File: rtl/areset_seq_sync_if.sv
// Reset-sequencer control bundle: software reset request in, sequenced resets and
// completion flag out. Master is the controller side; slave is the sequencer.
interface areset_seq_sync_if #(
    parameter int NCH = 3
);
    logic           i_sw_rst;
    logic [NCH-1:0] o_rst;
    logic           o_rst_done;

    modport master (
        output i_sw_rst,
        input  o_rst,
        input  o_rst_done
    );

    modport slave (
        input  i_sw_rst,
        output o_rst,
        output o_rst_done
    );
endinterface

// File: rtl/areset_seq_sync.sv
// Async reset synchronizer with programmable hold and staggered release of NCH
// reset channels, each with its own asserted polarity, plus a sync software reset.
module areset_seq_sync #(
    parameter int             STAGES  = 2,
    parameter int             NCH     = 3,
    parameter int             STRETCH = 16,
    parameter int             GAP     = 4,
    parameter logic [NCH-1:0] OUT_POL = '0
) (
    input  logic               clk,
    input  logic               i_rst_async,
    areset_seq_sync_if.slave   bus
);

    if (STAGES < 2 || NCH < 1 || STRETCH < 1 || GAP < 1) begin : g_param_check
        $error("areset_seq_sync: need STAGES>=2, NCH>=1, STRETCH>=1, GAP>=1");
    end

    localparam int MAXC = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // Assertion is asynchronous; only the falling edge is retimed into clk.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic rst_int;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_int = sync_q[STAGES-1];

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [CHW-1:0]     ch_q,    ch_d;
    logic [NCH-1:0]     rst_q,   rst_d;
    logic               done_q,  done_d;

    always_ff @(posedge clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= OUT_POL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        done_d  = done_q;

        if (rst_int || bus.i_sw_rst) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            ch_d    = '0;
            rst_d   = OUT_POL;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
                ST_STRETCH: begin
                    if (cnt_q == CW'(STRETCH - 1)) begin
                        rst_d[0] = ~OUT_POL[0];
                        cnt_d    = '0;
                        ch_d     = CHW'(1);
                        state_d  = (NCH == 1) ? ST_DONE : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CW'(GAP - 1)) begin
                        for (int k = 0; k < NCH; k++) begin
                            if (CHW'(k) == ch_q) rst_d[k] = ~OUT_POL[k];
                        end
                        cnt_d = '0;
                        if (ch_q == CHW'(NCH - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            ch_d = ch_q + CHW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    assign bus.o_rst      = rst_q;
    assign bus.o_rst_done = done_q;

endmodule

// File: tb/tb_areset_seq_sync.sv
// Directed and random bench for areset_seq_sync: a release-time model fills a
// per-edge scoreboard that is drained and compared after each clock edge.
module tb_areset_seq_sync;

    logic clk  = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;

    always #5 clk = ~clk;

    areset_seq_sync_if #(.NCH(3)) bus0 ();
    areset_seq_sync_if #(.NCH(1)) bus1 ();

    areset_seq_sync #(
        .OUT_POL (3'b001)
    ) u_dut0 (
        .clk         (clk),
        .i_rst_async (rst0),
        .bus         (bus0.slave)
    );

    areset_seq_sync #(
        .STAGES  (3),
        .NCH     (1),
        .STRETCH (1)
    ) u_dut1 (
        .clk         (clk),
        .i_rst_async (rst1),
        .bus         (bus1.slave)
    );

    typedef struct {
        int         dut;
        string      tag;
        logic [2:0] rst;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Per-instance configuration, written out independently of the RTL.
    task automatic get_cfg(input int dut, output int nch, output int st,
                           output int gap, output logic [2:0] pol);
        if (dut == 0) begin
            nch = 3; st = 16; gap = 4; pol = 3'b001;
        end else begin
            nch = 1; st = 1; gap = 1; pol = 3'b000;
        end
    endtask

    task automatic push_hold(input int dut, input string tag, input int n);
        int nch, st, gap;
        logic [2:0] pol;
        get_cfg(dut, nch, st, gap, pol);
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            x.dut  = dut;
            x.tag  = $sformatf("%s_e%0d", tag, e);
            x.rst  = pol;
            x.done = 1'b0;
            q.push_back(x);
        end
    endtask

    // e0 is the edge (counted from 1) at which the FSM leaves HOLD.
    task automatic push_seq(input int dut, input string tag, input int e0, input int n);
        int nch, st, gap;
        logic [2:0] pol;
        get_cfg(dut, nch, st, gap, pol);
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            x.dut = dut;
            x.tag = $sformatf("%s_e%0d", tag, e);
            x.rst = pol;
            for (int k = 0; k < nch; k++) begin
                if (e >= e0 + st + k * gap) x.rst[k] = ~pol[k];
            end
            x.done = (e >= e0 + st + (nch - 1) * gap + 1);
            q.push_back(x);
        end
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            exp_t x;
            logic [2:0] obs_rst;
            logic       obs_done;
            @(posedge clk);
            #1;
            x = q.pop_front();
            if (x.dut == 0) begin
                obs_rst  = bus0.o_rst;
                obs_done = bus0.o_rst_done;
            end else begin
                obs_rst  = {2'b00, bus1.o_rst};
                obs_done = bus1.o_rst_done;
            end
            check({x.tag, "_rst"}, obs_rst, x.rst);
            check({x.tag, "_done"}, {2'b00, obs_done}, {2'b00, x.done});
        end
    endtask

    initial begin
        logic [2:0] rel;
        logic       ra;
        logic       sw;

        bus0.i_sw_rst = 1'b0;
        bus1.i_sw_rst = 1'b0;
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        #1;
        check("reset_rst0",  bus0.o_rst, 3'b001);
        check("reset_done0", {2'b00, bus0.o_rst_done}, 3'b000);
        check("reset_rst1",  {2'b00, bus1.o_rst}, 3'b000);
        check("reset_done1", {2'b00, bus1.o_rst_done}, 3'b000);

        // Scenario 1: five cycles of reset, drop between edges, full release.
        push_hold(0, "s1hold", 5);
        drain();
        #2 rst0 = 1'b0;
        push_seq(0, "s1", 3, 30);
        drain();

        // Scenario 2: software reset for three edges from DONE.
        #2 bus0.i_sw_rst = 1'b1;
        push_hold(0, "s2sw", 3);
        drain();
        bus0.i_sw_rst = 1'b0;
        push_seq(0, "s2", 1, 30);
        drain();

        // Scenario 3: async reset after channel 0 released, channel 1 pending.
        #2 bus0.i_sw_rst = 1'b1;
        push_hold(0, "s3sw", 1);
        drain();
        bus0.i_sw_rst = 1'b0;
        push_seq(0, "s3pre", 1, 18);
        drain();
        #2 rst0 = 1'b1;
        #1;
        check("s3_async_rst",  bus0.o_rst, 3'b001);
        check("s3_async_done", {2'b00, bus0.o_rst_done}, 3'b000);
        push_hold(0, "s3hold", 2);
        drain();
        #2 rst0 = 1'b0;
        push_seq(0, "s3", 3, 30);
        drain();

        // Scenario 4: 3 ns glitch, entirely between two edges.
        #1 rst0 = 1'b1;
        #1;
        check("s4_glitch_rst",  bus0.o_rst, 3'b001);
        check("s4_glitch_done", {2'b00, bus0.o_rst_done}, 3'b000);
        #2 rst0 = 1'b0;
        push_seq(0, "s4", 3, 30);
        drain();

        // Scenario 5: single channel, STRETCH=1, three-stage synchronizer.
        push_hold(1, "s5hold", 2);
        drain();
        #2 rst1 = 1'b0;
        push_seq(1, "s5", 4, 8);
        drain();

        // Scenario 6: random software and async resets, ordering invariants.
        ra = 1'b0;
        sw = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            rel = bus0.o_rst ^ 3'b001;
            check("rand_order", {2'b00, (rel[1] & ~rel[0]) | (rel[2] & ~rel[1])}, 3'b000);
            check("rand_done", {2'b00, bus0.o_rst_done & (rel != 3'b111)}, 3'b000);
            if (ra || sw) begin
                check("rand_held_rst", bus0.o_rst, 3'b001);
                check("rand_held_done", {2'b00, bus0.o_rst_done}, 3'b000);
            end
            #1;
            if (ra) ra = ($urandom_range(0, 3) != 0);
            else    ra = ($urandom_range(0, 499) == 0);
            if (sw) sw = ($urandom_range(0, 2) != 0);
            else    sw = ($urandom_range(0, 149) == 0);
            rst0 = ra;
            bus0.i_sw_rst = sw;
        end

        bus0.i_sw_rst = 1'b0;
        rst0 = 1'b1;
        push_hold(0, "finhold", 2);
        drain();
        #2 rst0 = 1'b0;
        push_seq(0, "fin", 3, 30);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
